// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one multi-cycle single-port SRAM between IF and MEM,
//               with MEM priority, ready pulses, freeze and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int SRAM_WAIT = 3,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          mem_r_en,
    input  logic          mem_w_en,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic [31:0]   mem_rdata,
    output logic          mem_ready,
    output logic          freeze,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic          sram_we,
    output logic          sram_oe,
    input  logic [31:0]   sram_rdata,
    output logic [31:0]   stall_count
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_BUSY      = 2'd1;
    localparam logic [1:0] c_DONE      = 2'd2;
    localparam logic       c_OWN_IF    = 1'b0;
    localparam logic       c_OWN_MEM   = 1'b1;
    localparam logic [3:0] c_WAIT_INIT = 4'(SRAM_WAIT - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_owner;
    logic       r_op;      // 1 = write
    logic [3:0] r_cnt;
    logic       w_mem_req;
    logic       w_grant;
    logic       w_last;

    // Byte-offset and high address bits never reach the SRAM.
    logic w_addr_unused;
    assign w_addr_unused = ^{if_addr[31:AW+2], if_addr[1:0],
                             mem_addr[31:AW+2], mem_addr[1:0]};

    assign w_mem_req = mem_r_en | mem_w_en;
    assign w_last    = (r_state == c_BUSY) && (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_mem_req | if_req) begin
                    w_grant      = 1'b1;
                    w_next_state = c_BUSY;
                end
            end
            c_BUSY: begin
                if (r_cnt == 4'd0) w_next_state = c_DONE;
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= c_OWN_IF;
            r_op        <= 1'b0;
            r_cnt       <= 4'd0;
            sram_addr   <= '0;
            sram_wdata  <= 32'd0;
            if_rdata    <= 32'd0;
            mem_rdata   <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner   <= w_mem_req ? c_OWN_MEM : c_OWN_IF;
                r_op      <= w_mem_req & mem_w_en;
                sram_addr <= w_mem_req ? mem_addr[AW+1:2] : if_addr[AW+1:2];
                r_cnt     <= c_WAIT_INIT;
                if (w_mem_req & mem_w_en) sram_wdata <= mem_wdata;
            end else if (r_state == c_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_last && !r_op) begin
                if (r_owner == c_OWN_MEM) mem_rdata <= sram_rdata;
                else                      if_rdata  <= sram_rdata;
            end

            if (freeze) stall_count <= stall_count + 32'd1;
        end
    end

    assign sram_oe   = (r_state == c_BUSY) && !r_op;
    assign sram_we   = (r_state == c_BUSY) &&  r_op;
    assign mem_ready = (r_state == c_DONE) && (r_owner == c_OWN_MEM);
    // A fetch flushed while in flight completes silently.
    assign if_ready  = (r_state == c_DONE) && (r_owner == c_OWN_IF) && if_req;
    assign freeze    = w_mem_req & ~mem_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (SRAM_WAIT = 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        freeze;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic [31:0] sram_rdata;
    logic [31:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sram_mem [0:1023];

    always #5 clk = ~clk;

    assign sram_rdata = sram_mem[sram_addr[9:0]];
    always @(posedge clk) if (sram_we) sram_mem[sram_addr[9:0]] <= sram_wdata;

    mem_arbiter #(.SRAM_WAIT(3), .AW(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .freeze(freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata),
        .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram_mem[i] = 32'hA000_0000 + 32'(i);

        // Reset with random inputs
        rst = 1'b1;
        if_req = 1'($urandom); if_addr = $urandom;
        mem_r_en = 1'($urandom); mem_w_en = ~mem_r_en & 1'($urandom);
        mem_addr = $urandom; mem_wdata = $urandom;
        step();
        step();
        rst = 1'b0;
        idle_inputs();
        mid();
        check("rst_if_ready",  {31'd0, if_ready},  32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_freeze",    {31'd0, freeze},    32'd0);
        check("rst_sram_en",   {30'd0, sram_we, sram_oe}, 32'd0);
        check("rst_if_rdata",  if_rdata,  32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_stall",     stall_count, 32'd0);
        check("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
        check("rst_sram_wdata", sram_wdata, 32'd0);
        step(); mid();
        check("rst_after_en",  {30'd0, sram_we, sram_oe}, 32'd0);

        // Single fetch
        step(); if_req = 1'b1; if_addr = 32'h10; mid();
        check("fetch_c0_oe", {31'd0, sram_oe}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            step(); mid();
            check("fetch_oe",   {31'd0, sram_oe}, 32'd1);
            check("fetch_addr", {16'd0, sram_addr}, 32'h4);
            check("fetch_rdy_early", {31'd0, if_ready}, 32'd0);
        end
        step(); mid();
        check("fetch_ready", {31'd0, if_ready}, 32'd1);
        check("fetch_rdata", if_rdata, 32'hA000_0004);
        check("fetch_oe_done", {31'd0, sram_oe}, 32'd0);
        step(); if_req = 1'b0; mid();
        check("fetch_ready_c5", {31'd0, if_ready}, 32'd0);

        // Contention: MEM wins, IF follows
        step();
        if_req = 1'b1; if_addr = 32'h20; mem_r_en = 1'b1; mem_addr = 32'h8;
        mid();
        check("cont_freeze_c0", {31'd0, freeze}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            step(); mid();
            check("cont_freeze", {31'd0, freeze}, 32'd1);
            check("cont_addr", {16'd0, sram_addr}, 32'h2);
            check("cont_mem_rdy_early", {31'd0, mem_ready}, 32'd0);
        end
        step(); mid();
        check("cont_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("cont_mem_rdata", mem_rdata, 32'hA000_0002);
        check("cont_freeze_c4", {31'd0, freeze}, 32'd0);
        check("cont_if_ready_c4", {31'd0, if_ready}, 32'd0);
        step(); mem_r_en = 1'b0; mid();
        check("cont_oe_c5", {31'd0, sram_oe}, 32'd0);
        step(); mid();
        check("cont_if_oe_c6", {31'd0, sram_oe}, 32'd1);
        check("cont_if_addr", {16'd0, sram_addr}, 32'h8);
        step(); step(); mid();
        check("cont_if_rdy_c8", {31'd0, if_ready}, 32'd0);
        step(); mid();
        check("cont_if_ready", {31'd0, if_ready}, 32'd1);
        check("cont_if_rdata", if_rdata, 32'hA000_0008);
        check("cont_stall", stall_count, 32'd4);
        check("cont_mem_rdata_hold", mem_rdata, 32'hA000_0002);
        step(); if_req = 1'b0; mid();

        // Store then load
        step();
        mem_w_en = 1'b1; mem_addr = 32'h408; mem_wdata = 32'hDEAD_BEEF;
        mid();
        for (int c = 1; c <= 3; c++) begin
            step(); mid();
            check("st_we",    {31'd0, sram_we}, 32'd1);
            check("st_oe",    {31'd0, sram_oe}, 32'd0);
            check("st_addr",  {16'd0, sram_addr}, 32'h102);
            check("st_wdata", sram_wdata, 32'hDEAD_BEEF);
        end
        step(); mid();
        check("st_ready", {31'd0, mem_ready}, 32'd1);
        check("st_we_done", {31'd0, sram_we}, 32'd0);
        check("st_stall", stall_count, 32'd8);
        step(); mem_w_en = 1'b0; mem_r_en = 1'b1; mid();
        check("ld_freeze_c5", {31'd0, freeze}, 32'd1);
        for (int c = 6; c <= 8; c++) begin
            step(); mid();
            check("ld_oe", {31'd0, sram_oe}, 32'd1);
        end
        step(); mid();
        check("ld_ready", {31'd0, mem_ready}, 32'd1);
        check("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("ld_stall", stall_count, 32'd12);
        step(); idle_inputs(); mid();

        // Reset in the middle of a write
        step(); mem_w_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1234_5678; mid();
        step(); mid();
        step(); rst = 1'b1; mid();
        check("rstw_we_c2", {31'd0, sram_we}, 32'd1);
        step(); rst = 1'b0; idle_inputs(); mid();
        check("rstw_we_c3", {31'd0, sram_we}, 32'd0);
        check("rstw_ready_c3", {31'd0, mem_ready}, 32'd0);
        check("rstw_stall", stall_count, 32'd0);
        step(); if_req = 1'b1; if_addr = 32'h18; mid();
        check("rstw_ready_c4", {31'd0, mem_ready}, 32'd0);
        check("rstw_en_c4", {30'd0, sram_we, sram_oe}, 32'd0);
        step(); mid();
        check("rstw_idle_grant", {31'd0, sram_oe}, 32'd1);
        check("rstw_idle_addr", {16'd0, sram_addr}, 32'h6);
        step(); step(); step(); mid();
        check("rstw_if_ready", {31'd0, if_ready}, 32'd1);
        step(); if_req = 1'b0; mid();

        // Flushed fetch, then a new fetch requested from IDLE
        step(); if_req = 1'b1; if_addr = 32'h30; mid();
        step(); mid();
        step(); if_req = 1'b0; mid();
        check("flush_oe_c2", {31'd0, sram_oe}, 32'd1);
        step(); mid();
        step(); mid();
        check("flush_no_ready", {31'd0, if_ready}, 32'd0);
        step(); if_req = 1'b1; if_addr = 32'h14; mid();
        check("flush_oe_c5", {31'd0, sram_oe}, 32'd0);
        step(); mid();
        check("flush_oe_c6", {31'd0, sram_oe}, 32'd1);
        check("flush_addr_c6", {16'd0, sram_addr}, 32'h5);
        step(); step(); step(); mid();
        check("flush_ready_c9", {31'd0, if_ready}, 32'd1);
        check("flush_rdata_c9", if_rdata, 32'hA000_0005);
        step(); idle_inputs(); mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller that shares one single-port, multi-cycle SRAM between the instruction-fetch stage and the MEM stage of the 5-stage ARM pipeline. It grants the SRAM to one requester at a time and runs a fixed-length wait sequence per access. It returns read data with a one-cycle ready pulse, drives the pipeline-wide `freeze` while a data access is outstanding, and counts frozen cycles for performance reporting.

## Interface
- `SRAM_WAIT`, 3: SRAM access length in cycles; legal range 1..15.
- `AW`, 16: SRAM word-address width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_ready`.
- `if_addr`  in  32  fetch byte address.
- `if_rdata`  out  32  fetched instruction; valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `mem_r_en`  in  1  data read request; held until `mem_ready`.
- `mem_w_en`  in  1  data write request; held until `mem_ready`. Never high together with `mem_r_en`.
- `mem_addr`  in  32  data byte address, already offset by the MEM stage.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  load data; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle completion pulse for a data access.
- `freeze`  out  1  stall for IF/ID/EXE/MEM pipeline registers.
- `sram_addr`  out  AW  SRAM word address, equal to the granted `addr[AW+1:2]`.
- `sram_wdata`  out  32  SRAM write data.
- `sram_we`  out  1  SRAM write enable.
- `sram_oe`  out  1  SRAM output enable.
- `sram_rdata`  in  32  SRAM read data; valid on the last wait cycle.
- `stall_count`  out  32  count of cycles with `freeze`=1.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. An `owner` register records which requester holds the SRAM: IF or MEM. An `op` register records the access type: read or write.
- **IDLE**
  - If `mem_r_en|mem_w_en` is high: grant MEM and set `op` from `mem_w_en`.
  - Otherwise, if `if_req` is high: grant IF with `op`=read.
  - Otherwise: stay in IDLE.
  - On a grant: latch the address (and data for a write) into `sram_addr`/`sram_wdata`, load the wait counter with `SRAM_WAIT-1`, and go to BUSY.
- **BUSY**
  - `sram_oe`=1 for reads; `sram_we`=1 for writes.
  - `sram_addr` and `sram_wdata` stay stable for the whole state.
  - The counter decrements each cycle.
  - When the counter is 0: capture `sram_rdata` into the owner's rdata register (reads only) and go to DONE.
- **DONE**
  - `mem_ready` = (owner==MEM).
  - `if_ready` = (owner==IF) & `if_req`. The gate on `if_req` drops a fetch flushed by a branch.
  - No grant is made in DONE. Next state is always IDLE.
- MEM has fixed priority. An access in progress is never preempted, even by a MEM request.
- IF cannot starve: MEM issues at most one request per instruction, and that request is absent while the instruction is frozen.
- `freeze` = (`mem_r_en|mem_w_en`) & ~`mem_ready`. This output is combinational.
- `stall_count` increments by 1 each cycle `freeze`=1 and wraps modulo 2^32.
- `if_rdata`/`mem_rdata` hold their last captured value outside of ready pulses.

## Timing
- Cycle n is the interval after rising edge n.
- A request present in cycle 0 of IDLE is granted at edge 1:
  - BUSY covers cycles 1..`SRAM_WAIT`.
  - DONE/ready is in cycle `SRAM_WAIT`+1.
  - IDLE is in cycle `SRAM_WAIT`+2.
- Each access occupies `SRAM_WAIT`+2 cycles. Back-to-back accesses therefore start every `SRAM_WAIT`+2 cycles.
- Reset values: state=IDLE, owner=IF, counter=0. All outputs are 0, including `sram_we`, `sram_oe`, the ready pulses, both rdata registers, `stall_count` and `freeze`.
- Reset mid-access aborts the access:
  - From the next cycle, `sram_we`/`sram_oe` are 0 and no ready pulse is produced.
  - Already-written SRAM contents are undefined.
- If `if_req` drops mid-access, the SRAM access still completes and the arbiter returns to IDLE normally.
- A request asserted in the DONE cycle is granted in the following IDLE cycle.

## Test plan
All scenarios use `SRAM_WAIT`=3 and an SRAM model that returns `mem[sram_addr]` on the last wait cycle.
- **Reset:** hold `rst` 2 cycles with random inputs -> all outputs 0, `stall_count`=0, no SRAM enable in the cycle after reset.
- **Single fetch:** `if_req`=1, `if_addr`=0x10 in cycle 0 -> `sram_oe`=1 with `sram_addr`=0x4 in cycles 1-3; `if_ready`=1 with `if_rdata`=`mem[4]` in cycle 4 only.
- **Contention:** `if_req`=1 and `mem_r_en`=1 with `mem_addr`=0x8 in cycle 0, both held until their ready ->
  - `mem_ready` in cycle 4 and `freeze` high in cycles 0-3.
  - IF granted at edge 6; `if_ready` in cycle 9.
  - `stall_count`=4.
- **Store then load:** `mem_w_en`, `mem_addr`=0x408, `mem_wdata`=0xDEADBEEF -> `sram_addr`=0x102 and `sram_we`=1 in cycles 1-3 with stable data; `mem_ready` in cycle 4. A read of 0x408 then returns `mem_rdata`=0xDEADBEEF.
- **Reset mid-write:** `rst`=1 in cycle 2 of a write -> `sram_we`=0 from cycle 3, no `mem_ready`, state IDLE.
- **Flushed fetch:** `if_req` dropped in cycle 2 of a fetch -> no `if_ready` in cycle 4. A new `if_req` in cycle 5 is granted at edge 6.
